// File: rtl/cpu_hazard_scoreboard.sv
// Decode-to-execute issue controller: tracks pending writes of long-latency ops,
// stalls on RAW/WAW/capacity hazards, sequences fence drains and latches faults.
module cpu_hazard_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_TIMEOUT   = 1024,
    parameter int CNT_W           = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [2:0]       i_have_rs,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [4:0]       i_rs3,
    input  logic [4:0]       i_rd,
    input  logic             i_long,
    input  logic             i_fence,
    input  logic             i_exec_ready,
    input  logic             i_wb_valid,
    input  logic [4:0]       i_wb_rd,
    output logic             o_issue,
    output logic             o_stall,
    output logic [31:0]      o_pending,
    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_fault
);

    localparam int SC_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STALL_TIMEOUT);
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    function automatic logic [31:0] onehot32(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    state_t           state_r, state_next_s;
    logic [31:0]      pending_r, pending_next_s;
    logic [CNT_W-1:0] outstanding_r, outstanding_next_s, out_eff_s;
    logic [SC_W-1:0]  stall_cnt_r, stall_cnt_next_s;
    logic             fault_r;
    logic [31:0]      wb_mask_s, eff_pending_s, set_mask_s;
    logic             raw_s, waw_s, full_s, hazard_s, drain_go_s;
    logic             issue_s, stall_s, fault_event_s;

    // Reset synchronizer: asserts immediately, releases on the clock
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Hazard detection against pending bits after same-cycle writeback
    always_comb begin
        wb_mask_s     = i_wb_valid ? onehot32(i_wb_rd) : 32'd0;
        eff_pending_s = pending_r & ~wb_mask_s;
        out_eff_s     = outstanding_r - CNT_W'(i_wb_valid);
        raw_s = (i_have_rs[0] & eff_pending_s[i_rs1]) |
                (i_have_rs[1] & eff_pending_s[i_rs2]) |
                (i_have_rs[2] & eff_pending_s[i_rs3]);
        waw_s    = i_long & (i_rd != 5'd0) & eff_pending_s[i_rd];
        full_s   = i_long & (out_eff_s == CNT_MAX);
        hazard_s = raw_s | waw_s | full_s;
    end

    // Issue/stall decision and next state
    always_comb begin
        stall_s      = 1'b0;
        issue_s      = 1'b0;
        drain_go_s   = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                drain_go_s = i_valid & i_fence & ~hazard_s & (out_eff_s != {CNT_W{1'b0}});
                stall_s    = i_valid & (hazard_s | ~i_exec_ready | drain_go_s);
                issue_s    = i_valid & ~stall_s;
                if (drain_go_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                stall_s = i_valid;
                if (out_eff_s == {CNT_W{1'b0}}) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_FAULT: begin
                stall_s      = i_valid;
                state_next_s = ST_FAULT;
            end
            default: begin
                stall_s      = i_valid;
                state_next_s = ST_FAULT;
            end
        endcase

        // Orphan/underflow writebacks and watchdog expiry are all fatal
        fault_event_s = (state_r != ST_FAULT) & (
                        (i_wb_valid & (outstanding_r == {CNT_W{1'b0}})) |
                        (i_wb_valid & (i_wb_rd != 5'd0) & ~pending_r[i_wb_rd]) |
                        (stall_s & (stall_cnt_r >= SC_LAST)));
        if (fault_event_s) begin
            state_next_s = ST_FAULT;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Pending bits, outstanding count and stall watchdog next values
    always_comb begin
        set_mask_s = (issue_s & i_long & (i_rd != 5'd0)) ? onehot32(i_rd) : 32'd0;
        pending_next_s = ((pending_r & ~wb_mask_s) | set_mask_s) & ~32'd1;
        case ({issue_s & i_long, i_wb_valid & (outstanding_r != {CNT_W{1'b0}})})
            2'b10:   outstanding_next_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_next_s = outstanding_r - CNT_W'(1);
            default: outstanding_next_s = outstanding_r;
        endcase
        if (stall_s) begin
            if (stall_cnt_r != SC_MAX) begin
                stall_cnt_next_s = stall_cnt_r + SC_W'(1);
            end else begin
                stall_cnt_next_s = stall_cnt_r;
            end
        end else begin
            stall_cnt_next_s = {SC_W{1'b0}};
        end
    end

    // State registers; tracking is frozen once faulted
    always_ff @(posedge i_clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r       <= ST_RUN;
            pending_r     <= 32'd0;
            outstanding_r <= {CNT_W{1'b0}};
            stall_cnt_r   <= {SC_W{1'b0}};
            fault_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            fault_r <= fault_r | fault_event_s;
            if (state_r != ST_FAULT) begin
                pending_r     <= pending_next_s;
                outstanding_r <= outstanding_next_s;
                stall_cnt_r   <= stall_cnt_next_s;
            end
        end
    end

    assign o_issue       = issue_s & rst_n_s;
    assign o_stall       = stall_s & rst_n_s;
    assign o_pending     = pending_r;
    assign o_outstanding = outstanding_r;
    assign o_fault       = fault_r;

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle, a negedge monitor checks them.
module tb_cpu_hazard_scoreboard;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [2:0]  i_have_rs;
    logic [4:0]  i_rs1, i_rs2, i_rs3, i_rd;
    logic        i_long, i_fence, i_exec_ready, i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic        o_issue, o_stall, o_fault;
    logic [31:0] o_pending;
    logic [4:0]  o_outstanding;

    cpu_hazard_scoreboard #(
        .MAX_OUTSTANDING(4),
        .STALL_TIMEOUT(1024),
        .CNT_W(5)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_have_rs(i_have_rs),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs3(i_rs3), .i_rd(i_rd), .i_long(i_long),
        .i_fence(i_fence), .i_exec_ready(i_exec_ready), .i_wb_valid(i_wb_valid),
        .i_wb_rd(i_wb_rd), .o_issue(o_issue), .o_stall(o_stall), .o_pending(o_pending),
        .o_outstanding(o_outstanding), .o_fault(o_fault)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [127:0] tag;
        logic         chk_comb;
        logic         issue;
        logic         stall;
        logic         chk_reg;
        logic [31:0]  pending;
        logic [4:0]   outstanding;
        logic         fault;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input logic [127:0] tag, input logic [63:0] field,
                         input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %0s.%0s: got 0x%0h expected 0x%0h at %0t", tag, field, act, want, $time);
        end
    endtask

    // Monitor: consume every expectation queued for this cycle
    always @(negedge i_clock) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_comb) begin
                check(mon_e.tag, "issue", {31'd0, o_issue}, {31'd0, mon_e.issue});
                check(mon_e.tag, "stall", {31'd0, o_stall}, {31'd0, mon_e.stall});
            end
            if (mon_e.chk_reg) begin
                check(mon_e.tag, "pending", o_pending, mon_e.pending);
                check(mon_e.tag, "outst", {27'd0, o_outstanding}, {27'd0, mon_e.outstanding});
                check(mon_e.tag, "fault", {31'd0, o_fault}, {31'd0, mon_e.fault});
            end
        end
    end

    task automatic nxt();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] hrs, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic lng, input logic fen,
                       input logic rdy, input logic wbv, input logic [4:0] wbrd);
        i_valid = v; i_have_rs = hrs; i_rs1 = rs1; i_rs2 = 5'd0; i_rs3 = 5'd0;
        i_rd = rd; i_long = lng; i_fence = fen; i_exec_ready = rdy;
        i_wb_valid = wbv; i_wb_rd = wbrd;
    endtask

    task automatic idle(input logic wbv, input logic [4:0] wbrd);
        drv(1'b0, 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, wbv, wbrd);
    endtask

    task automatic exp_c(input logic [127:0] tag, input logic iss, input logic stl);
        exp_t t;
        t = '0;
        t.tag = tag; t.chk_comb = 1'b1; t.issue = iss; t.stall = stl;
        exp_q.push_back(t);
    endtask

    task automatic exp_r(input logic [127:0] tag, input logic [31:0] pend,
                         input logic [4:0] outst, input logic flt);
        exp_t t;
        t = '0;
        t.tag = tag; t.chk_reg = 1'b1; t.pending = pend; t.outstanding = outst; t.fault = flt;
        exp_q.push_back(t);
    endtask

    initial begin
        // Reset with a valid instruction present: nothing may issue or stall
        i_reset = 1'b0;
        drv(1'b1, 3'b000, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        repeat (2) nxt();
        exp_c("rst", 1'b0, 1'b0);
        exp_r("rst", 32'd0, 5'd0, 1'b0);
        nxt();
        i_reset = 1'b1;
        idle(1'b0, 5'd0);
        repeat (3) nxt();

        // RAW on a load result, resolved by same-cycle writeback
        drv(1'b1, 3'b000, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("ld5", 1'b1, 1'b0);
        nxt();
        drv(1'b1, 3'b001, 5'd5, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("raw5", 1'b0, 1'b1);
        exp_r("raw5", 32'h0000_0020, 5'd1, 1'b0);
        nxt();
        drv(1'b1, 3'b001, 5'd5, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
        exp_c("raw5_wb", 1'b1, 1'b0);
        nxt();
        idle(1'b0, 5'd0);
        exp_r("raw5_clr", 32'd0, 5'd0, 1'b0);

        // Long op to x0 counts but never sets a pending bit
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("ld0", 1'b1, 1'b0);
        nxt();
        drv(1'b1, 3'b001, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("use0", 1'b1, 1'b0);
        exp_r("ld0", 32'd0, 5'd1, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        exp_c("notready", 1'b0, 1'b1);
        exp_r("ld0_hold", 32'd0, 5'd1, 1'b0);
        nxt();
        idle(1'b0, 5'd0);
        exp_r("ld0_wb", 32'd0, 5'd0, 1'b0);

        // Fill to the outstanding limit, then a writeback frees a slot
        for (int k = 1; k <= 4; k++) begin
            nxt();
            drv(1'b1, 3'b000, 5'd0, 5'(k), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
            exp_c("fill", 1'b1, 1'b0);
        end
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("full", 1'b0, 1'b1);
        exp_r("full", 32'h0000_001E, 5'd4, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
        exp_c("full_wb", 1'b1, 1'b0);
        nxt();
        idle(1'b1, 5'd2);
        exp_r("full_swap", 32'h0000_005C, 5'd4, 1'b0);
        nxt(); idle(1'b1, 5'd3);
        nxt(); idle(1'b1, 5'd4);
        nxt(); idle(1'b1, 5'd6);
        nxt(); idle(1'b0, 5'd0);
        exp_r("full_drain", 32'd0, 5'd0, 1'b0);

        // Fence waits in DRAIN until both loads retire, then issues in RUN
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("ld8", 1'b1, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("ld9", 1'b1, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
        exp_c("fence", 1'b0, 1'b1);
        exp_r("fence", 32'h0000_0300, 5'd2, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8);
        exp_c("drain1", 1'b0, 1'b1);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9);
        exp_c("drain2", 1'b0, 1'b1);
        exp_r("drain2", 32'h0000_0200, 5'd1, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
        exp_c("fence_iss", 1'b1, 1'b0);
        exp_r("fence_iss", 32'd0, 5'd0, 1'b0);

        // Writeback with nothing outstanding faults; reset clears it at once
        nxt();
        idle(1'b1, 5'd3);
        exp_r("uf_pre", 32'd0, 5'd0, 1'b0);
        nxt();
        drv(1'b1, 3'b000, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("flt_blk", 1'b0, 1'b1);
        exp_r("flt_set", 32'd0, 5'd0, 1'b1);
        nxt();
        exp_c("flt_blk2", 1'b0, 1'b1);
        exp_r("flt_stay", 32'd0, 5'd0, 1'b1);
        nxt();
        i_reset = 1'b0;
        exp_c("rst_mid", 1'b0, 1'b0);
        exp_r("rst_mid", 32'd0, 5'd0, 1'b0);
        nxt();
        i_reset = 1'b1;
        idle(1'b0, 5'd0);
        repeat (3) nxt();

        // Watchdog: fault lands on the edge ending the 1024th stalled cycle
        drv(1'b1, 3'b000, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        exp_c("to_ld", 1'b1, 1'b0);
        for (int i = 1; i <= 1024; i++) begin
            nxt();
            drv(1'b1, 3'b001, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
            if (i == 1) exp_c("to_stall", 1'b0, 1'b1);
            if (i == 1024) exp_r("to_edge", 32'h0000_0400, 5'd1, 1'b0);
        end
        nxt();
        exp_c("to_blk", 1'b0, 1'b1);
        exp_r("to_fault", 32'h0000_0400, 5'd1, 1'b1);
        nxt();
        idle(1'b0, 5'd0);
        @(negedge i_clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_hazard_scoreboard.md
Name: cpu_hazard_scoreboard

Overview:
- Issue controller between CPU decode and execute stages.
- Tracks destination registers of in-flight long-latency instructions (loads, complex/multi-cycle ALU ops) and stalls decode-to-execute issue on RAW/WAW hazards.
- Limits outstanding long ops, sequences fence drains, and raises a sticky fault on watchdog expiry or on an inconsistent writeback.

Parameters:
- MAX_OUTSTANDING, 4: maximum in-flight long ops; 1..31.
- STALL_TIMEOUT, 1024: consecutive stalled cycles before fault; >=2.
- CNT_W, 5: width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- i_clock  in  1  clock, rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  decoded instruction present.
- i_have_rs  in  3  {rs3,rs2,rs1} used flags.
- i_rs1, i_rs2, i_rs3  in  5 each  source register indices.
- i_rd  in  5  destination register.
- i_long  in  1  instruction is a long op (memory_read or complex) that writes rd later.
- i_fence  in  1  instruction is a fence; issues only when drained.
- i_exec_ready  in  1  execute stage can accept.
- i_wb_valid  in  1  a long op completes this cycle.
- i_wb_rd  in  5  register written by the completing op.
- o_issue  out  1  instruction transfers to execute this cycle.
- o_stall  out  1  decode must hold its output.
- o_pending  out  32  pending-write bit per register; bit0 always 0.
- o_outstanding  out  CNT_W  in-flight long-op count.
- o_fault  out  1  sticky fault.

Behaviour:
- Reset (async assert, sync deassert internally): pending=0, outstanding=0, stall counter=0, state=RUN, o_fault=0. Consequently o_issue=0, o_stall=0 (i_valid is don't-care during reset).
- States: RUN, DRAIN, FAULT.
- eff_pending = pending & ~(i_wb_valid ? onehot(i_wb_rd) : 0). A same-cycle writeback resolves the hazard (write-first register file).
- hazard = RAW on any used rs with eff_pending[rs], or (i_long and i_rd!=0 and eff_pending[i_rd]) for WAW, or (i_long and outstanding_eff==MAX_OUTSTANDING), where outstanding_eff = outstanding - i_wb_valid.
- Register 0 is never hazardous and never set pending.
- RUN:
  - o_stall = i_valid & (hazard | !i_exec_ready).
  - o_issue = i_valid & !o_stall.
  - i_valid & i_fence & !hazard & outstanding_eff!=0: go to DRAIN; no issue this cycle.
- DRAIN:
  - o_stall = i_valid; o_issue = 0.
  - Next cycle after outstanding_eff==0, return to RUN. The fence then issues via the normal RUN rule.
- FAULT: o_stall = i_valid, o_issue = 0, pending and count frozen. Exit only on reset.
- Updates at clock edge:
  - Issue with i_long & i_rd!=0 sets pending[i_rd] and adds 1 to the count.
  - Issue with i_long & i_rd==0 adds to the count only.
  - A valid writeback clears pending[i_wb_rd] and subtracts 1. Simultaneous +1/-1 leaves the count unchanged.
  - Same-cycle wb and issue to the same rd leaves the bit set.
- Writeback while outstanding==0: fault.
- Writeback to a nonzero rd whose pending bit is 0: fault.
- Any fault goes to FAULT next cycle with o_fault=1.
- Stall counter:
  - Increments each cycle o_stall=1.
  - Clears on o_issue or !i_valid.
  - Saturates. Reaching STALL_TIMEOUT gives FAULT.
- Outputs o_pending, o_outstanding and o_fault are registered. o_issue and o_stall are combinational.

Test Plan:
- Issue long op rd=5; next cycle i_valid, rs1=5, have_rs=001 -> o_stall=1, o_pending[5]=1. Set wb_rd=5 -> same cycle o_issue=1, next cycle o_pending[5]=0.
- Long op rd=0, then rs1=0 consumer -> consumer issues with no stall; o_pending stays 0; outstanding=1 until wb.
- Issue 4 long ops to rd=1..4 (MAX=4); 5th long op rd=6 -> stall. Same cycle wb_rd=1 -> 5th issues, count stays 4.
- 2 outstanding, i_fence -> DRAIN with o_stall=1. wb,wb -> RUN the cycle after; fence issues then.
- wb_valid with outstanding=0 -> o_fault=1 next cycle, all later issues blocked. Assert i_reset=0 mid-stall -> all outputs 0 immediately.
- Hold hazard 1024 cycles (STALL_TIMEOUT=1024) -> o_fault rises on the 1024th stalled cycle edge.
